lock_ctrl_fsm: RTL and testbench
================================

Name: lock_ctrl_fsm

Overview:
Sequencing controller for the code-lock datapath: it interprets debounced key strobes plus the 4-bit switch code as lock commands. It collects 4-digit entries, compares them against a stored password, opens and closes the lock, handles password change, and enforces a lockout after repeated failures. It sits between the key debouncer and the seven-segment scan driver, which shows disp_data.

Parameters:
DEFAULT_PW, 16'h1234, password loaded at reset (4 BCD digits, MSD first)
OPEN_TICKS, 1000, cycles the lock stays open without a close command
ERR_TICKS, 100, cycles the ERROR state is held
LOCK_TICKS, 5000, cycles the LOCKOUT state is held
MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..3)
CNT_W, 16, timer width; must hold max(OPEN_TICKS, ERR_TICKS, LOCK_TICKS)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
key_pulse  in  1  one-cycle strobe from the debouncer; marks a key press
Sw  in  4  key code, sampled only in the cycle key_pulse=1
Close_sig  out  1  lock closed
OPEN_sig  out  1  lock open
ERROR_sig  out  1  wrong code / lockout indication
Change_word  out  1  password-change mode active
Lockout  out  1  lockout in progress
disp_data  out  16  entered digits, newest in [3:0]
disp_cnt  out  3  number of digits entered (0..4)
fail_cnt  out  2  consecutive mismatch count

Behaviour:
- Codes: 0-9 are digits; A, B and C are ignored everywhere; E = start entry; F = change password; D = confirm/close.
- All outputs are registered. A key_pulse in cycle n updates state and outputs at n+1. Rst overrides a key_pulse in the same cycle.
- Reset values: state IDLE, pw=DEFAULT_PW, buffer=0, disp_cnt=0, fail_cnt=0, timer=0. Close_sig=1; OPEN_sig, ERROR_sig, Change_word and Lockout are 0.
- Close_sig=1 in every state except OPEN and CHANGE. OPEN_sig=1 in OPEN and CHANGE. Change_word=1 only in CHANGE. ERROR_sig=1 in ERROR and LOCKOUT. Lockout=1 only in LOCKOUT.
- Digit entry, in ENTRY and CHANGE only:
  - A digit with disp_cnt<4 does buffer <= {buffer[11:0],Sw} and disp_cnt+1.
  - A digit with disp_cnt==4 is ignored; the buffer does not wrap.
  - E clears the buffer and disp_cnt.
- IDLE: E -> ENTRY with buffer cleared. Every other key is ignored.
- ENTRY:
  - D with disp_cnt==4 -> CHECK.
  - D with disp_cnt<4 -> CHECK, forced mismatch.
  - F is ignored.
- CHECK lasts exactly 1 cycle and ignores keys.
  - Match: -> OPEN, fail_cnt=0.
  - Mismatch: fail_cnt+1; -> LOCKOUT if the new count equals MAX_FAIL, otherwise -> ERROR.
- OPEN:
  - Timer runs. Timeout -> IDLE.
  - D -> IDLE (manual close).
  - F -> CHANGE with buffer cleared.
  - E and digits are ignored and do not restart the timer.
- CHANGE:
  - No timeout.
  - D with disp_cnt==4: pw <= buffer -> IDLE (lock closes with the new password).
  - D with disp_cnt<4: abort; pw unchanged -> OPEN with the timer restarted.
- ERROR: hold ERR_TICKS cycles -> IDLE. Keys are ignored.
- LOCKOUT: hold LOCK_TICKS cycles -> IDLE with fail_cnt=0. Keys are ignored.
- Timer: cleared on every state entry; increments each cycle in timed states. Exit occurs when timer==TICKS-1, so each timed state lasts exactly TICKS cycles. A D key and a timeout in the same OPEN cycle both give IDLE.
- Buffer and disp_cnt are cleared on every entry to IDLE, ENTRY and CHANGE. They hold during CHECK, ERROR and LOCKOUT.
- pw is never exposed on a port. Reset mid-operation restores DEFAULT_PW.

Test Plan:
Bench parameters: OPEN_TICKS=8, ERR_TICKS=4, LOCK_TICKS=16.
- Correct entry: E,1,2,3,4,D -> CHECK 1 cycle after D, then OPEN_sig=1 and Close_sig=0 for exactly 8 cycles, then Close_sig=1. disp_data=16'h1234 and disp_cnt=4 before D.
- Password change: E1234D, then F,5,2,3,5,D -> Change_word=1 after F, IDLE after D. Then E1234D -> ERROR_sig=1 for 4 cycles and fail_cnt=1. Then E5235D -> OPEN_sig=1 and fail_cnt=0.
- Lockout: E1111D three times -> fail_cnt 1, 2, then LOCKOUT with Lockout=1 and ERROR_sig=1 for 16 cycles. A key_pulse during lockout has no effect. Exit leaves fail_cnt=0.
- Boundaries:
  - E,1,2,3,4,5 -> disp_data=16'h1234 (5th digit dropped).
  - E,1,2,D -> mismatch (ERROR).
  - A/B/C presses leave all outputs unchanged.
  - In OPEN, D closes immediately; in CHANGE, F,5,D aborts to OPEN with pw still 1234.
- Reset mid-operation: change pw to 5235, assert Rst for 1 cycle together with a key_pulse -> all outputs at reset values. E1234D then opens.

Source files
------------

// File: rtl/lock_ctrl_fsm.sv
// lock_ctrl_fsm: code-lock sequencer for entry, compare, open/close, password change and lockout
module lock_ctrl_fsm #(
  parameter logic [15:0] DEFAULT_PW = 16'h1234,
  parameter int OPEN_TICKS = 1000,
  parameter int ERR_TICKS = 100,
  parameter int LOCK_TICKS = 5000,
  parameter int MAX_FAIL = 3,
  parameter int CNT_W = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        key_pulse,
  input  logic [3:0]  Sw,
  output logic        Close_sig,
  output logic        OPEN_sig,
  output logic        ERROR_sig,
  output logic        Change_word,
  output logic        Lockout,
  output logic [15:0] disp_data,
  output logic [2:0]  disp_cnt,
  output logic [1:0]  fail_cnt
);
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, CHANGE, ERROR, LOCKOUT} state_t;
  state_t state, state_d;
  logic [15:0] pw, pw_d, buf_d;
  logic [2:0] cnt_d;
  logic [1:0] fail_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic digit, k_e, k_f, k_d, editing, full;
  assign digit = key_pulse && Sw <= 4'd9;
  assign k_e = key_pulse && Sw == 4'hE;
  assign k_f = key_pulse && Sw == 4'hF;
  assign k_d = key_pulse && Sw == 4'hD;
  assign editing = state == ENTRY || state == CHANGE;
  assign full = disp_cnt == 3'd4;
  always_comb begin
    state_d = state;
    pw_d = pw;
    buf_d = disp_data;
    cnt_d = disp_cnt;
    fail_d = fail_cnt;
    case (state)
      IDLE: state_d = k_e ? ENTRY : IDLE;
      ENTRY: state_d = k_d ? CHECK : ENTRY;
      CHECK: begin
        fail_d = (full && disp_data == pw) ? 2'd0 : fail_cnt + 2'd1;
        state_d = (full && disp_data == pw) ? OPEN : (fail_d == 2'(MAX_FAIL)) ? LOCKOUT : ERROR;
      end
      OPEN: state_d = (k_d || timer == CNT_W'(OPEN_TICKS - 1)) ? IDLE : k_f ? CHANGE : OPEN;
      CHANGE: begin
        state_d = k_d ? (full ? IDLE : OPEN) : CHANGE;
        pw_d = (k_d && full) ? disp_data : pw;
      end
      ERROR: state_d = (timer == CNT_W'(ERR_TICKS - 1)) ? IDLE : ERROR;
      LOCKOUT: begin
        state_d = (timer == CNT_W'(LOCK_TICKS - 1)) ? IDLE : LOCKOUT;
        fail_d = (timer == CNT_W'(LOCK_TICKS - 1)) ? 2'd0 : fail_cnt;
      end
      default: state_d = IDLE;
    endcase
    if (editing && digit && !full) begin
      buf_d = {disp_data[11:0], Sw};
      cnt_d = disp_cnt + 3'd1;
    end
    if ((editing && k_e) || (state_d != state && state_d inside {IDLE, ENTRY, CHANGE})) begin
      buf_d = '0;
      cnt_d = '0;
    end
    timer_d = (state_d != state || !(state inside {OPEN, ERROR, LOCKOUT})) ? '0 : timer + CNT_W'(1);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      pw <= DEFAULT_PW;
      timer <= '0;
      disp_data <= '0;
      disp_cnt <= '0;
      fail_cnt <= '0;
      Close_sig <= 1'b1;
      OPEN_sig <= 1'b0;
      ERROR_sig <= 1'b0;
      Change_word <= 1'b0;
      Lockout <= 1'b0;
    end else begin
      state <= state_d;
      pw <= pw_d;
      timer <= timer_d;
      disp_data <= buf_d;
      disp_cnt <= cnt_d;
      fail_cnt <= fail_d;
      Close_sig <= !(state_d inside {OPEN, CHANGE});
      OPEN_sig <= state_d inside {OPEN, CHANGE};
      ERROR_sig <= state_d inside {ERROR, LOCKOUT};
      Change_word <= state_d == CHANGE;
      Lockout <= state_d == LOCKOUT;
    end
  end
endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb_lock_ctrl_fsm: vector table plus directed sequences for the code-lock sequencer
module tb_lock_ctrl_fsm;
  logic Clk = 0, Rst = 1, key_pulse = 0;
  logic [3:0] Sw = 0;
  logic Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout;
  logic [15:0] disp_data;
  logic [2:0] disp_cnt;
  logic [1:0] fail_cnt;
  int errors = 0, checks = 0;

  lock_ctrl_fsm #(.OPEN_TICKS(8), .ERR_TICKS(4), .LOCK_TICKS(16)) dut (
    .Clk(Clk), .Rst(Rst), .key_pulse(key_pulse), .Sw(Sw),
    .Close_sig(Close_sig), .OPEN_sig(OPEN_sig), .ERROR_sig(ERROR_sig),
    .Change_word(Change_word), .Lockout(Lockout),
    .disp_data(disp_data), .disp_cnt(disp_cnt), .fail_cnt(fail_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic kp;
    logic [3:0] sw;
    logic [4:0] flags;
    logic [15:0] data;
    logic [2:0] cnt;
    logic [1:0] fail;
  } vec_t;
  vec_t v [28];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_pulse = 1;
    Sw = c;
    @(negedge Clk);
    key_pulse = 0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(4'hE); press(a); press(b); press(c); press(d); press(4'hD);
  endtask

  task automatic count_while(input int sel, output int n);
    n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (!(sel == 0 ? OPEN_sig : sel == 1 ? ERROR_sig : Lockout)) break;
      n++;
    end
  endtask

  task automatic wait_err_clear();
    for (int i = 0; i < 40 && ERROR_sig; i++) @(negedge Clk);
    chk("err_exit", {31'd0, ERROR_sig}, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_flags"}, {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b10000);
    chk({nm, "_data"}, {16'd0, disp_data}, 0);
    chk({nm, "_cnt"}, {29'd0, disp_cnt}, 0);
    chk({nm, "_fail"}, {30'd0, fail_cnt}, 0);
  endtask

  initial begin
    int n;
    v[0]  = '{1'b1, 4'hA, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[1]  = '{1'b1, 4'h1, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[2]  = '{1'b1, 4'hE, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[3]  = '{1'b1, 4'hB, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[4]  = '{1'b1, 4'h1, 5'b10000, 16'h0001, 3'd1, 2'd0};
    v[5]  = '{1'b1, 4'h2, 5'b10000, 16'h0012, 3'd2, 2'd0};
    v[6]  = '{1'b0, 4'h3, 5'b10000, 16'h0012, 3'd2, 2'd0};
    v[7]  = '{1'b1, 4'h3, 5'b10000, 16'h0123, 3'd3, 2'd0};
    v[8]  = '{1'b1, 4'h4, 5'b10000, 16'h1234, 3'd4, 2'd0};
    v[9]  = '{1'b1, 4'h5, 5'b10000, 16'h1234, 3'd4, 2'd0};
    v[10] = '{1'b1, 4'hF, 5'b10000, 16'h1234, 3'd4, 2'd0};
    v[11] = '{1'b1, 4'hC, 5'b10000, 16'h1234, 3'd4, 2'd0};
    v[12] = '{1'b1, 4'hD, 5'b10000, 16'h1234, 3'd4, 2'd0};
    v[13] = '{1'b0, 4'h0, 5'b01000, 16'h1234, 3'd4, 2'd0};
    v[14] = '{1'b1, 4'hE, 5'b01000, 16'h1234, 3'd4, 2'd0};
    v[15] = '{1'b1, 4'hD, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[16] = '{1'b1, 4'hE, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[17] = '{1'b1, 4'h1, 5'b10000, 16'h0001, 3'd1, 2'd0};
    v[18] = '{1'b1, 4'h2, 5'b10000, 16'h0012, 3'd2, 2'd0};
    v[19] = '{1'b1, 4'hE, 5'b10000, 16'h0000, 3'd0, 2'd0};
    v[20] = '{1'b1, 4'h1, 5'b10000, 16'h0001, 3'd1, 2'd0};
    v[21] = '{1'b1, 4'h2, 5'b10000, 16'h0012, 3'd2, 2'd0};
    v[22] = '{1'b1, 4'hD, 5'b10000, 16'h0012, 3'd2, 2'd0};
    v[23] = '{1'b0, 4'h0, 5'b10100, 16'h0012, 3'd2, 2'd1};
    v[24] = '{1'b0, 4'h0, 5'b10100, 16'h0012, 3'd2, 2'd1};
    v[25] = '{1'b0, 4'h0, 5'b10100, 16'h0012, 3'd2, 2'd1};
    v[26] = '{1'b0, 4'h0, 5'b10100, 16'h0012, 3'd2, 2'd1};
    v[27] = '{1'b0, 4'h0, 5'b10000, 16'h0000, 3'd0, 2'd1};

    repeat (2) @(negedge Clk);
    chk_reset_vals("reset");
    Rst = 0;

    foreach (v[i]) begin
      key_pulse = v[i].kp;
      Sw = v[i].sw;
      @(negedge Clk);
      key_pulse = 0;
      chk($sformatf("vec%0d_flags", i), {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, {27'd0, v[i].flags});
      chk($sformatf("vec%0d_data", i), {16'd0, disp_data}, {16'd0, v[i].data});
      chk($sformatf("vec%0d_cnt", i), {29'd0, disp_cnt}, {29'd0, v[i].cnt});
      chk($sformatf("vec%0d_fail", i), {30'd0, fail_cnt}, {30'd0, v[i].fail});
    end

    enter(1, 2, 3, 4);
    chk("check_fail_held", {30'd0, fail_cnt}, 1);
    chk("check_closed", {31'd0, Close_sig}, 1);
    @(negedge Clk);
    chk("open_fail_clr", {30'd0, fail_cnt}, 0);
    chk("open_close0", {31'd0, Close_sig}, 0);
    count_while(0, n);
    chk("open_len", n, 8);
    chk("open_timeout_close", {31'd0, Close_sig}, 1);

    enter(1, 2, 3, 4);
    @(negedge Clk);
    press(4'hF);
    chk("chg_flags", {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b01010);
    chk("chg_buf_clr", {29'd0, disp_cnt}, 0);
    press(5); press(2); press(3); press(5);
    chk("chg_data", {16'd0, disp_data}, 32'h5235);
    press(4'hD);
    chk("chg_done", {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b10000);
    enter(1, 2, 3, 4);
    @(negedge Clk);
    chk("oldpw_err", {31'd0, ERROR_sig}, 1);
    chk("oldpw_fail", {30'd0, fail_cnt}, 1);
    count_while(1, n);
    chk("err_len", n, 4);
    enter(5, 2, 3, 5);
    @(negedge Clk);
    chk("newpw_open", {31'd0, OPEN_sig}, 1);
    chk("newpw_fail", {30'd0, fail_cnt}, 0);

    press(4'hF); press(5); press(4'hD);
    chk("abort_flags", {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b01000);
    count_while(0, n);
    chk("abort_open_len", n, 8);
    enter(5, 2, 3, 5);
    @(negedge Clk);
    chk("abort_pw_kept", {31'd0, OPEN_sig}, 1);
    press(4'hD);
    chk("manual_close", {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b10000);

    enter(1, 1, 1, 1);
    @(negedge Clk);
    chk("lk_fail1", {30'd0, fail_cnt}, 1);
    wait_err_clear();
    enter(1, 1, 1, 1);
    @(negedge Clk);
    chk("lk_fail2", {30'd0, fail_cnt}, 2);
    wait_err_clear();
    enter(1, 1, 1, 1);
    @(negedge Clk);
    chk("lk_flags", {27'd0, Close_sig, OPEN_sig, ERROR_sig, Change_word, Lockout}, 32'b10101);
    chk("lk_fail3", {30'd0, fail_cnt}, 3);
    press(4'hE);
    chk("lk_key_ignored", {13'd0, Lockout, disp_data, disp_cnt}, {13'd0, 1'b1, 16'h1111, 3'd4});
    count_while(2, n);
    chk("lk_len", n + 1, 16);
    chk("lk_exit_fail", {30'd0, fail_cnt}, 0);
    chk("lk_exit_err", {31'd0, ERROR_sig}, 0);

    enter(5, 2, 3, 5);
    @(negedge Clk);
    press(4'hF); press(5); press(2); press(3); press(5); press(4'hD);
    press(4'hE); press(7);
    Rst = 1;
    key_pulse = 1;
    Sw = 4'h8;
    @(negedge Clk);
    Rst = 0;
    key_pulse = 0;
    chk_reset_vals("midrst");
    enter(1, 2, 3, 4);
    @(negedge Clk);
    chk("midrst_default_pw", {31'd0, OPEN_sig}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
